// File: rtl/prefix_scan_pkg.sv
// Shared constants, prefix vector layout and merge helpers for the
// x86 prefix scanner (optional VEX decode via PREFIX_SCAN_VEX_EN).
package prefix_scan_pkg;

`ifndef PREF_LAYOUT_DEFINED
`define PREF_LAYOUT_DEFINED
`define PREF_LOCK   0
`define PREF_REPE   1
`define PREF_REPNE  2
`define PREF_HASSEG 3
`define PREF_SEG_LO 4
`define PREF_SEG_HI 6
`define PREF_DATA   7
`define PREF_ADDR   8
`define PREF_REX    9
`define PREF_REX_W  10
`define PREF_REX_R  11
`define PREF_REX_X  12
`define PREF_REX_B  13
`define PREF_2BYTE  14
`define PREF_WIDTH  15
`endif

  localparam int PREF_W = `PREF_WIDTH;

  localparam logic [7:0] B_LOCK  = 8'hF0;
  localparam logic [7:0] B_REPE  = 8'hF3;
  localparam logic [7:0] B_REPNE = 8'hF2;
  localparam logic [7:0] B_CS    = 8'h2E;
  localparam logic [7:0] B_SS    = 8'h36;
  localparam logic [7:0] B_DS    = 8'h3E;
  localparam logic [7:0] B_ES    = 8'h26;
  localparam logic [7:0] B_FS    = 8'h64;
  localparam logic [7:0] B_GS    = 8'h65;
  localparam logic [7:0] B_DATA  = 8'h66;
  localparam logic [7:0] B_ADDR  = 8'h67;
  localparam logic [7:0] B_ESC   = 8'h0F;
  localparam logic [7:0] B_VEX3  = 8'hC4;
  localparam logic [7:0] B_VEX2  = 8'hC5;

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef enum logic [0:0] {
    SCAN = ST_SCAN,
    HOLD = ST_HOLD
  } state_e;

  typedef struct packed {
    logic       two_byte;
    logic       rex_b;
    logic       rex_x;
    logic       rex_r;
    logic       rex_w;
    logic       rex;
    logic       addr;
    logic       data;
    logic [2:0] seg;
    logic       hasseg;
    logic       repne;
    logic       repe;
    logic       lock;
  } pref_t;

  function automatic logic is_rex(
    input logic [7:0] b,
    input logic       m64
  );
    return m64 && (b[7:4] == 4'h4);
  endfunction

  function automatic logic is_legacy(input logic [7:0] b);
    case (b)
      B_LOCK, B_REPE, B_REPNE,
      B_CS, B_SS, B_DS, B_ES, B_FS, B_GS,
      B_DATA, B_ADDR: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic is_prefix(
    input logic [7:0] b,
    input logic       m64
  );
    return is_legacy(b) || is_rex(b, m64) || (b == B_ESC);
  endfunction

  // A legacy prefix after REX makes that REX ineffective.
  function automatic pref_t pref_merge(
    input pref_t      acc,
    input logic [7:0] b,
    input logic       m64
  );
    pref_t r;
    r = acc;
    if (is_rex(b, m64)) begin
      r.rex   = 1'b1;
      r.rex_w = b[3];
      r.rex_r = b[2];
      r.rex_x = b[1];
      r.rex_b = b[0];
    end else if (is_legacy(b)) begin
      {r.rex, r.rex_w, r.rex_r, r.rex_x, r.rex_b} = '0;
      case (b)
        B_LOCK:  r.lock  = 1'b1;
        B_REPE:  r.repe  = 1'b1;
        B_REPNE: r.repne = 1'b1;
        B_DATA:  r.data  = 1'b1;
        B_ADDR:  r.addr  = 1'b1;
        B_CS:    begin r.hasseg = 1'b1; r.seg = 3'd0; end
        B_SS:    begin r.hasseg = 1'b1; r.seg = 3'd1; end
        B_DS:    begin r.hasseg = 1'b1; r.seg = 3'd2; end
        B_ES:    begin r.hasseg = 1'b1; r.seg = 3'd3; end
        B_FS:    begin r.hasseg = 1'b1; r.seg = 3'd4; end
        B_GS:    begin r.hasseg = 1'b1; r.seg = 3'd5; end
        default: ;
      endcase
    end else if (b == B_ESC) begin
      r.two_byte = 1'b1;
    end
    return r;
  endfunction

  // Fold a window-local vector onto the running accumulator.
  function automatic pref_t pref_join(
    input pref_t acc,
    input pref_t win,
    input logic  legacy
  );
    pref_t r;
    r = acc;
    r.lock     = acc.lock     | win.lock;
    r.repe     = acc.repe     | win.repe;
    r.repne    = acc.repne    | win.repne;
    r.data     = acc.data     | win.data;
    r.addr     = acc.addr     | win.addr;
    r.two_byte = acc.two_byte | win.two_byte;
    if (win.hasseg) begin
      r.hasseg = 1'b1;
      r.seg    = win.seg;
    end
    if (win.rex) begin
      r.rex   = 1'b1;
      r.rex_w = win.rex_w;
      r.rex_r = win.rex_r;
      r.rex_x = win.rex_x;
      r.rex_b = win.rex_b;
    end else if (legacy) begin
      {r.rex, r.rex_w, r.rex_r, r.rex_x, r.rex_b} = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_window_dec.sv
// Combinational decode of one fetch window: per-byte classes, the
// first terminal byte and the window-local merged prefix vector.
module prefix_window_dec
  import prefix_scan_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1),
  parameter int IW = $clog2(W)
) (
  input  logic [8*W-1:0] i_bytes,
  input  logic [CW-1:0]  i_cnt,
  input  logic           i_mode64,
  output logic [W-1:0]   o_is_pref,
  output logic [W-1:0]   o_is_term,
  output pref_t          o_vec,
  output logic           o_legacy,
  output logic [IW-1:0]  o_idx,
  output logic           o_found
);

  logic [7:0] w_b [W];

  always_comb begin
    for (int i = 0; i < W; i++) begin
      w_b[i] = i_bytes[8*i +: 8];
    end
  end

  always_comb begin
    o_is_pref = '0;
    o_is_term = '0;
    o_vec     = '0;
    o_legacy  = 1'b0;
    o_idx     = '0;
    o_found   = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(i_cnt)) begin
        o_is_pref[i] = is_prefix(w_b[i], i_mode64);
        o_is_term[i] = !is_prefix(w_b[i], i_mode64)
                     || (w_b[i] == B_ESC);
      end
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (o_is_term[i]) begin
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
    // 0F is both terminal and part of the prefix run.
    for (int i = 0; i < W; i++) begin
      if ((i < int'(i_cnt))
          && (!o_found || (i < int'(o_idx))
              || ((i == int'(o_idx)) && (w_b[i] == B_ESC)))) begin
        o_vec = pref_merge(o_vec, w_b[i], i_mode64);
        if (is_legacy(w_b[i])) o_legacy = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prefix_scan.sv
// Sequential x86 legacy/REX prefix scanner over W-byte windows.
// Define PREFIX_SCAN_VEX_EN to decode C4/C5 as VEX escapes in 64-bit mode.
module prefix_scan
  import prefix_scan_pkg::*;
#(
  parameter int W      = 4,
  parameter int MAXLEN = 15,
  parameter int LW     = 4,
  parameter int CW     = $clog2(W + 1),
  parameter int IW     = $clog2(W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode64,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [8*W-1:0]    in_bytes,
  input  logic [CW-1:0]     in_cnt,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [PREF_W-1:0] out_pref,
  output logic [LW-1:0]     out_len,
  output logic [IW-1:0]     out_opc_off,
`ifdef PREFIX_SCAN_VEX_EN
  output logic              out_vex,
  output logic              out_vex3,
`endif
  output logic              out_fault
);

  localparam int SW = LW + 1;

  logic [0:0]    r_state;
  pref_t         r_acc;
  logic [LW-1:0] r_cnt;
  logic [IW-1:0] r_off;
  logic          r_fault;
  logic          r_opc_next;

  logic [W-1:0]  w_is_pref;
  logic [W-1:0]  w_is_term;
  pref_t         w_win;
  logic          w_legacy;
  logic [IW-1:0] w_dec_idx;
  logic          w_dec_found;

  logic          w_esc;
  logic          w_tail;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] w_np;
  logic [SW-1:0] w_sum;
  pref_t         w_merged;
  logic          w_len_fault;
  logic          w_done;
  logic          w_ud;

  prefix_window_dec #(.W(W), .CW(CW), .IW(IW)) u_dec (
    .i_bytes  (in_bytes),
    .i_cnt    (in_cnt),
    .i_mode64 (mode64),
    .o_is_pref(w_is_pref),
    .o_is_term(w_is_term),
    .o_vec    (w_win),
    .o_legacy (w_legacy),
    .o_idx    (w_dec_idx),
    .o_found  (w_dec_found)
  );

`ifdef PREFIX_SCAN_VEX_EN
  logic       r_vex;
  logic       r_vex3;
  logic       w_vex;
  logic       w_vex3;
  logic [7:0] w_tbyte;
`endif

  always_comb begin
    w_esc = w_dec_found
          && w_is_pref[w_dec_idx]
          && w_is_term[w_dec_idx];
    w_tail = 1'b0;
    if (r_opc_next) begin
      // Escape closed the previous window: byte 0 is the opcode.
      w_found  = 1'b1;
      w_idx    = '0;
      w_np     = '0;
      w_merged = r_acc;
    end else begin
      w_tail   = w_esc
               && ((CW'(w_dec_idx) + CW'(1)) == in_cnt);
      w_found  = w_dec_found;
      w_idx    = w_dec_idx + IW'(w_esc);
      w_np     = w_dec_found
               ? CW'(w_dec_idx) + CW'(w_esc)
               : in_cnt;
      w_merged = pref_join(r_acc, w_win, w_legacy);
    end
    w_sum       = SW'(r_cnt) + SW'(w_np);
    w_len_fault = w_sum >= SW'(MAXLEN);
    w_done      = w_found && !w_tail;
`ifdef PREFIX_SCAN_VEX_EN
    w_tbyte = in_bytes[8*w_dec_idx +: 8];
    w_vex   = mode64 && !r_opc_next && w_dec_found && !w_esc
            && ((w_tbyte == B_VEX3) || (w_tbyte == B_VEX2));
    w_vex3  = w_tbyte == B_VEX3;
    w_ud    = w_vex && (w_merged.data | w_merged.repe
            | w_merged.repne | w_merged.lock | w_merged.rex);
`else
    w_ud = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= ST_SCAN;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_off      <= '0;
      r_fault    <= 1'b0;
      r_opc_next <= 1'b0;
`ifdef PREFIX_SCAN_VEX_EN
      r_vex      <= 1'b0;
      r_vex3     <= 1'b0;
`endif
    end else if (r_state == ST_SCAN) begin
      if (in_vld) begin
        r_acc      <= w_merged;
        r_opc_next <= w_tail && !w_len_fault;
        if (w_len_fault) begin
          r_cnt   <= LW'(MAXLEN);
          r_fault <= 1'b1;
          r_state <= ST_HOLD;
        end else begin
          r_cnt <= w_sum[LW-1:0];
          if (w_done) begin
            r_off   <= w_idx;
            r_fault <= w_ud;
            r_state <= ST_HOLD;
`ifdef PREFIX_SCAN_VEX_EN
            r_vex   <= w_vex;
            r_vex3  <= w_vex && w_vex3;
`endif
          end
        end
      end
    end else if (out_rdy) begin
      r_state    <= ST_SCAN;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_off      <= '0;
      r_fault    <= 1'b0;
      r_opc_next <= 1'b0;
`ifdef PREFIX_SCAN_VEX_EN
      r_vex      <= 1'b0;
      r_vex3     <= 1'b0;
`endif
    end
  end

  assign in_rdy      = r_state == ST_SCAN;
  assign out_vld     = r_state == ST_HOLD;
  assign out_pref    = r_acc;
  assign out_len     = r_cnt;
  assign out_opc_off = r_off;
  assign out_fault   = r_fault;
`ifdef PREFIX_SCAN_VEX_EN
  assign out_vex     = r_vex;
  assign out_vex3    = r_vex3;
`endif

endmodule

// File: tb/tb_prefix_scan.sv
// Directed bench for prefix_scan with hand-computed expectations;
// VEX cases are selected by PREFIX_SCAN_VEX_EN.
module tb_prefix_scan;
  import prefix_scan_pkg::*;

  localparam int W  = 4;
  localparam int LW = 4;
  localparam int CW = 3;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode64;
  logic              flush;
  logic              in_vld;
  logic              in_rdy;
  logic [8*W-1:0]    in_bytes;
  logic [CW-1:0]     in_cnt;
  logic              out_vld;
  logic              out_rdy;
  logic [PREF_W-1:0] out_pref;
  logic [LW-1:0]     out_len;
  logic [IW-1:0]     out_opc_off;
  logic              out_fault;
`ifdef PREFIX_SCAN_VEX_EN
  logic              out_vex;
  logic              out_vex3;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  prefix_scan #(.W(W), .MAXLEN(15), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode64     (mode64),
    .flush      (flush),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_bytes   (in_bytes),
    .in_cnt     (in_cnt),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_pref   (out_pref),
    .out_len    (out_len),
    .out_opc_off(out_opc_off),
`ifdef PREFIX_SCAN_VEX_EN
    .out_vex    (out_vex),
    .out_vex3   (out_vex3),
`endif
    .out_fault  (out_fault)
  );

  always @(posedge clk) begin
    if (in_vld && (in_cnt == '0))
      $error("empty window driven");
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(
    input logic [31:0]   b,
    input logic [CW-1:0] c
  );
    int t = 0;
    while (!in_rdy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("send_rdy", 32'(in_rdy), 32'd1);
    in_vld   = 1'b1;
    in_bytes = b;
    in_cnt   = c;
    @(posedge clk); #1;
    in_vld   = 1'b0;
    in_bytes = '0;
    in_cnt   = 3'd1;
  endtask

  task automatic expect_res(
    input string tag,
    input pref_t p,
    input int    len,
    input int    off,
    input bit    flt
  );
    check({tag, "_vld"},   32'(out_vld),     32'd1);
    check({tag, "_pref"},  32'(out_pref),    32'(p));
    check({tag, "_len"},   32'(out_len),     32'(len));
    check({tag, "_off"},   32'(out_opc_off), 32'(off));
    check({tag, "_fault"}, 32'(out_fault),   32'(flt));
  endtask

  task automatic take();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    check("take_vld", 32'(out_vld), 32'd0);
    check("take_rdy", 32'(in_rdy),  32'd1);
  endtask

  initial begin
    pref_t e;
    rst      = 1'b1;
    flush    = 1'b0;
    mode64   = 1'b1;
    in_vld   = 1'b0;
    in_bytes = '0;
    in_cnt   = 3'd1;
    out_rdy  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_rdy",   32'(in_rdy),      32'd1);
    check("rst_vld",   32'(out_vld),     32'd0);
    check("rst_pref",  32'(out_pref),    32'd0);
    check("rst_len",   32'(out_len),     32'd0);
    check("rst_off",   32'(out_opc_off), 32'd0);
    check("rst_fault", 32'(out_fault),   32'd0);

    // 66 48 8B C0: REX right before opcode stays effective
    send(32'hC08B4866, 3'd4);
    e = '0; e.data = 1'b1; e.rex = 1'b1; e.rex_w = 1'b1;
    expect_res("t1", e, 2, 2, 1'b0);
    check("t1_inrdy", 32'(in_rdy), 32'd0);
    take();

    // 48 66 89 C0: legacy after REX kills REX
    send(32'hC0896648, 3'd4);
    e = '0; e.data = 1'b1;
    expect_res("t2", e, 2, 2, 1'b0);
    take();

    // F3 F3 F3 F3 | 26 0F 10 00
    send(32'hF3F3F3F3, 3'd4);
    check("t3_mid_vld", 32'(out_vld), 32'd0);
    send(32'h00100F26, 3'd4);
    e = '0; e.repe = 1'b1; e.hasseg = 1'b1;
    e.seg = 3'd3; e.two_byte = 1'b1;
    expect_res("t3", e, 6, 2, 1'b0);
    take();

    // four windows of 66 reach the length limit
    send(32'h66666666, 3'd4);
    send(32'h66666666, 3'd4);
    send(32'h66666666, 3'd4);
    check("t4_mid_vld", 32'(out_vld), 32'd0);
    send(32'h66666666, 3'd4);
    e = '0; e.data = 1'b1;
    check("t4_vld",   32'(out_vld),   32'd1);
    check("t4_fault", 32'(out_fault), 32'd1);
    check("t4_len",   32'(out_len),   32'd15);
    check("t4_pref",  32'(out_pref),  32'(e));
    take();

    // hold under back-pressure, then flush
    send(32'h0090F067, 3'd3);
    e = '0; e.addr = 1'b1; e.lock = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      expect_res("t5_hold", e, 2, 2, 1'b0);
      check("t5_inrdy", 32'(in_rdy), 32'd0);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("t5_flush_vld", 32'(out_vld),  32'd0);
    check("t5_flush_rdy", 32'(in_rdy),   32'd1);
    check("t5_flush_len", 32'(out_len),  32'd0);
    check("t5_flush_pref", 32'(out_pref), 32'd0);

    // flush beats a terminal window in the same cycle
    in_vld = 1'b1; in_bytes = 32'h00009066; in_cnt = 3'd2;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_vld = 1'b0;
    check("t6_flush_win", 32'(out_vld), 32'd0);

    // 0F on the last valid byte: opcode is next window byte 0
    send(32'h00000F66, 3'd2);
    check("t7_mid_vld", 32'(out_vld), 32'd0);
    send(32'h00000038, 3'd1);
    e = '0; e.data = 1'b1; e.two_byte = 1'b1;
    expect_res("t7", e, 2, 0, 1'b0);
    take();

    // mode64=0: 40 is INC, a terminal opcode
    mode64 = 1'b0;
    send(32'h00009040, 3'd2);
    e = '0;
    expect_res("t8", e, 0, 0, 1'b0);
    take();
    mode64 = 1'b1;

    // 66 C5 F8
    send(32'h00F8C566, 3'd3);
    e = '0; e.data = 1'b1;
`ifdef PREFIX_SCAN_VEX_EN
    expect_res("t9", e, 1, 1, 1'b1);
    check("t9_vex",  32'(out_vex),  32'd1);
    check("t9_vex3", 32'(out_vex3), 32'd0);
    take();
    send(32'h0000E2C4, 3'd2);
    e = '0;
    expect_res("t10", e, 0, 0, 1'b0);
    check("t10_vex",  32'(out_vex),  32'd1);
    check("t10_vex3", 32'(out_vex3), 32'd1);
`else
    expect_res("t9", e, 1, 1, 1'b0);
`endif
    take();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
